jt49_mave_ctl: RTL and testbench

Moving-average (boxcar) stage that wraps the filter delay line. It sits directly upstream of the delay stage and feeds its din and cen. It also consumes the delay stage's dout, and keeps a running sum acc += din − delayed_din. After reset or clear it runs a flush sequence that zero-fills the delay RAM, so the running sum starts from a consistent state.

---
 rtl/jt49_filt_pkg.sv | 23 ++
 rtl/jt49_mave_flush.sv | 46 ++++
 rtl/jt49_mave_ctl.sv | 89 ++++++++
 tb/tb_jt49_mave_ctl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/jt49_filt_pkg.sv
// Shared definitions for the boxcar filter controller and the delay-line users.
// Window length, accumulator width and flush length derive from dw/depth.
package jt49_filt_pkg;

    typedef enum logic {
        FLUSH = 1'b0,
        RUN   = 1'b1
    } filt_state_t;

    function automatic int win_len(input int depth);
        return 1 << depth;
    endfunction

    function automatic int acc_width(input int dw, input int depth);
        return dw + depth;
    endfunction

    // N RAM writes plus the two register stages inside the delay line
    function automatic int flush_len(input int depth);
        return (1 << depth) + 2;
    endfunction

endpackage

// File: rtl/jt49_mave_flush.sv
// FLUSH/RUN sequencer: counts flush ticks until the delay RAM holds only zeros.
module jt49_mave_flush
    import jt49_filt_pkg::*;
#(
    parameter int depth = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic cen,
    input  logic clr,
    output logic busy,
    output logic run_start
);

    localparam int FLUSH_N = flush_len(depth);
    localparam logic [depth+1:0] FLUSH_LAST = (depth+2)'(FLUSH_N - 1);

    filt_state_t      st;
    logic [depth+1:0] fcnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st   <= FLUSH;
            fcnt <= '0;
            busy <= 1'b1;
        end else if (cen) begin
            if (clr) begin
                st   <= FLUSH;
                fcnt <= '0;
                busy <= 1'b1;
            end else if (st == FLUSH) begin
                if (fcnt == FLUSH_LAST) begin
                    st   <= RUN;
                    fcnt <= '0;
                    busy <= 1'b0;
                end else begin
                    fcnt <= fcnt + 1'b1;
                end
            end
        end
    end

    // Marks the final flush tick; a simultaneous clr keeps us in FLUSH
    assign run_start = cen && !clr && (st == FLUSH) && (fcnt == FLUSH_LAST);

endmodule

// File: rtl/jt49_mave_ctl.sv
// Boxcar moving average around an external delay line: acc += din - delayed din,
// with a zero-fill flush after reset/clear and a saturating, sticky-error accumulator.
module jt49_mave_ctl
    import jt49_filt_pkg::*;
#(
    parameter int dw    = 8,
    parameter int depth = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cen,
    input  logic          clr,
    input  logic [dw-1:0] din,
    output logic [dw-1:0] dly_din,
    output logic          dly_cen,
    input  logic [dw-1:0] dly_dout,
    output logic [dw-1:0] dout,
    output logic          dout_vld,
    output logic          busy,
    output logic          err
);

    localparam int AW = acc_width(dw, depth);
    localparam int SW = AW + 2;

    logic                 run_start;
    logic [AW-1:0]        acc;
    logic signed [SW-1:0] sum;
    logic [AW-1:0]        acc_nxt;
    logic                 sat;

    // Sign bit set means underflow; bit AW set with sign clear means overflow
    function automatic logic [AW-1:0] clamp_acc(input logic signed [SW-1:0] s);
        if (s[SW-1])
            return '0;
        else if (s[SW-2])
            return '1;
        else
            return s[AW-1:0];
    endfunction

    function automatic logic sat_hit(input logic signed [SW-1:0] s);
        return s[SW-1] | s[SW-2];
    endfunction

    jt49_mave_flush #(.depth(depth)) u_flush (
        .clk       (clk),
        .rst_n     (rst_n),
        .cen       (cen),
        .clr       (clr),
        .busy      (busy),
        .run_start (run_start)
    );

    assign dly_cen = cen;
    assign dly_din = busy ? '0 : din;

    always_comb begin
        sum = $signed({2'b00, acc})
            + $signed({{(SW-dw){1'b0}}, din})
            - $signed({{(SW-dw){1'b0}}, dly_dout});
        acc_nxt = clamp_acc(sum);
        sat     = sat_hit(sum);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= '0;
            dout     <= '0;
            dout_vld <= 1'b0;
            err      <= 1'b0;
        end else begin
            dout_vld <= 1'b0;
            if (cen) begin
                if (clr || run_start) begin
                    acc  <= '0;
                    dout <= '0;
                end else if (!busy) begin
                    acc      <= acc_nxt;
                    dout     <= acc_nxt[AW-1:depth];
                    dout_vld <= 1'b1;
                    if (sat)
                        err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_jt49_mave_ctl.sv
// Bench for jt49_mave_ctl: behavioural window-sum model, per-cycle compare, directed + random stimulus.
module tb_jt49_mave_ctl;

    localparam int DW    = 8;
    localparam int DEPTH = 3;
    localparam int N     = 1 << DEPTH;
    localparam int MAXA  = (1 << (DW + DEPTH)) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cen = 1'b0;
    logic          clr = 1'b0;
    logic [DW-1:0] din = '0;
    logic [DW-1:0] dly_din;
    logic          dly_cen;
    logic [DW-1:0] dly_dout;
    logic [DW-1:0] dout;
    logic          dout_vld;
    logic          busy;
    logic          err;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    jt49_mave_ctl #(.dw(DW), .depth(DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cen      (cen),
        .clr      (clr),
        .din      (din),
        .dly_din  (dly_din),
        .dly_cen  (dly_cen),
        .dly_dout (dly_dout),
        .dout     (dout),
        .dout_vld (dout_vld),
        .busy     (busy),
        .err      (err)
    );

    // Delay-line stand-in: returns the sample written N cen ticks earlier.
    // Until N writes have happened it returns junk so an incomplete flush shows up.
    logic [DW-1:0]    ring [N];
    logic [DEPTH-1:0] wptr = '0;
    int               nwr = 0;
    logic             force_bad = 1'b0;
    logic [DW-1:0]    ring_out;

    always @(posedge clk) begin
        if (dly_cen) begin
            ring[wptr] <= dly_din;
            wptr       <= wptr + 1'b1;
            nwr        <= nwr + 1;
        end
    end

    assign ring_out = (nwr >= N) ? ring[wptr] : 8'hAA;
    assign dly_dout = force_bad ? 8'h40 : ring_out;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: output = (sum of the last N accepted samples) >> depth.
    int  hist[$];
    int  flush_left;
    int  m_acc;
    int  exp_dout;
    int  exp_vld;
    int  exp_busy;
    int  exp_err;
    logic chk_en = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            hist.delete();
            flush_left = N + 2;
            m_acc = 0; exp_dout = 0; exp_vld = 0; exp_busy = 1; exp_err = 0;
        end else begin
            exp_vld = 0;
            if (cen) begin
                if (clr) begin
                    hist.delete();
                    flush_left = N + 2;
                    m_acc = 0; exp_dout = 0; exp_busy = 1;
                end else if (flush_left > 0) begin
                    flush_left--;
                    exp_busy = (flush_left > 0) ? 1 : 0;
                end else begin
                    if (force_bad) begin
                        int s;
                        s = m_acc + int'(din) - 'h40;
                        if (s < 0) begin s = 0; exp_err = 1; end
                        if (s > MAXA) begin s = MAXA; exp_err = 1; end
                        m_acc = s;
                    end else begin
                        int s;
                        hist.push_back(int'(din));
                        if (hist.size() > N) void'(hist.pop_front());
                        s = 0;
                        foreach (hist[i]) s += hist[i];
                        m_acc = s;
                    end
                    exp_dout = m_acc >> DEPTH;
                    exp_vld  = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", int'(busy), exp_busy);
            chk("dout", int'(dout), exp_dout);
            chk("dout_vld", int'(dout_vld), exp_vld);
            chk("err", int'(err), exp_err);
            chk("dly_cen", int'(dly_cen), int'(cen));
            chk("dly_din", int'(dly_din), exp_busy ? 0 : int'(din));
        end
    end

    // Called at posedge+2; returns at posedge+2 right after the cen edge.
    task automatic send(input logic [DW-1:0] d, input logic k);
        repeat (3) begin
            cen = 1'b0; din = d; clr = 1'b0;
            @(posedge clk); #2;
        end
        cen = 1'b1; din = d; clr = k;
        @(posedge clk); #2;
        cen = 1'b0; clr = 1'b0;
    endtask

    task automatic do_reset();
        chk_en = 1'b0;
        rst_n  = 1'b0;
        cen = 1'b0; clr = 1'b0;
        @(posedge clk); #2;
        chk("rst_busy", int'(busy), 1);
        chk("rst_dout", int'(dout), 0);
        chk("rst_vld", int'(dout_vld), 0);
        chk("rst_err", int'(err), 0);
        @(posedge clk); #2;
        rst_n  = 1'b1;
        chk_en = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        @(posedge clk); #2;
        do_reset();

        // Flush lasts exactly N+2 ticks, din ignored
        for (int i = 1; i <= N + 2; i++) begin
            send(8'hFF, 1'b0);
            chk("flush_busy", int'(busy), (i < N + 2) ? 1 : 0);
            chk("flush_dout", int'(dout), 0);
        end

        // Ramp with constant 0x10
        for (int k = 1; k <= N + 2; k++) begin
            send(8'h10, 1'b0);
            chk("ramp10", int'(dout), (k < N) ? 2 * k : 'h10);
            chk("ramp10_vld", int'(dout_vld), 1);
        end

        // Step to 0x50
        for (int k = 1; k <= N + 2; k++) begin
            send(8'h50, 1'b0);
            chk("step50", int'(dout), (k < N) ? 'h10 + 8 * k : 'h50);
        end

        // Full scale fits exactly
        for (int k = 1; k <= N; k++) send(8'hFF, 1'b0);
        chk("fullscale_dout", int'(dout), 'hFF);
        chk("fullscale_acc", int'(dut.acc), 'h7F8);
        chk("fullscale_err", int'(err), 0);

        // Mid-RUN clear, then the ramp restarts from 0x02
        send(8'h33, 1'b1);
        chk("clr_busy", int'(busy), 1);
        chk("clr_dout", int'(dout), 0);
        chk("clr_vld", int'(dout_vld), 0);
        for (int i = 1; i <= N + 2; i++) send(8'h77, 1'b0);
        chk("clr_flush_done", int'(busy), 0);
        for (int k = 1; k <= 3; k++) begin
            send(8'h10, 1'b0);
            chk("ramp_again", int'(dout), 2 * k);
        end

        // Clear landing on the final flush tick overrides entry to RUN
        send(8'h00, 1'b1);
        for (int i = 1; i <= N + 1; i++) send(8'h00, 1'b0);
        send(8'h00, 1'b1);
        chk("clr_override", int'(busy), 1);

        // Random traffic with occasional clears
        for (int i = 0; i < 4000; i++) begin
            cen = ($urandom_range(0, 2) == 0);
            din = DW'($urandom);
            clr = ($urandom_range(0, 299) == 0);
            @(posedge clk); #2;
        end
        cen = 1'b0; clr = 1'b0;

        // Inconsistent delay path: clamp at zero and sticky err
        send(8'h00, 1'b1);
        for (int i = 1; i <= N + 2; i++) send(8'h00, 1'b0);
        send(8'h10, 1'b0);
        chk("bad_pre", int'(dout), 'h02);
        force_bad = 1'b1;
        send(8'h00, 1'b0);
        chk("bad_clamp_dout", int'(dout), 0);
        chk("bad_clamp_acc", int'(dut.acc), 0);
        chk("bad_err", int'(err), 1);
        send(8'h20, 1'b0);
        chk("bad_err_hold", int'(err), 1);
        force_bad = 1'b0;
        send(8'h00, 1'b1);
        chk("err_after_clr", int'(err), 1);
        for (int i = 1; i <= N + 2; i++) send(8'h00, 1'b0);
        chk("err_after_flush", int'(err), 1);
        send(8'h08, 1'b0);
        chk("err_still", int'(err), 1);
        do_reset();
        chk("err_cleared", int'(err), 0);
        send(8'h00, 1'b0);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
